// File: rtl/camera_sccb_config_if.sv
// ---------------------------------------------------------------------------
// camera_sccb_config_if
// Bundles the signals between the OV7670 configuration sequencer, its
// register ROM and the SCCB pads.
//   sio_c     : SCCB clock (push-pull)
//   sio_d_o   : SCCB data value
//   sio_d_oe  : SCCB data drive enable (pad tristated when 0)
//   rom_addr  : ROM entry index
//   rom_data  : {reg_addr[15:8], value[7:0]}, valid one cycle after rom_addr
// Modports:
//   master : the sequencer (drives bus and ROM address, reads ROM data)
//   slave  : ROM / pad side
// ---------------------------------------------------------------------------
interface camera_sccb_config_if;
    logic        sio_c;
    logic        sio_d_o;
    logic        sio_d_oe;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data;

    modport master (
        output sio_c,
        output sio_d_o,
        output sio_d_oe,
        output rom_addr,
        input  rom_data
    );

    modport slave (
        input  sio_c,
        input  sio_d_o,
        input  sio_d_oe,
        input  rom_addr,
        output rom_data
    );
endinterface

// File: rtl/camera_sccb_config.sv
// ---------------------------------------------------------------------------
// camera_sccb_config
// Boot-time OV7670 register loader. Walks a ROM of {reg_addr, value} pairs
// and issues one 3-phase SCCB write (device ID, register, data) per entry.
// ROM sentinels: 16'hFFFF ends the pass, 16'hFFF0 waits DELAY_CYCLES.
// Ports:
//   clk          : camera-domain clock
//   reset_n      : synchronous active-low reset
//   start        : one-cycle pulse, starts a pass (honoured in IDLE/DONE)
//   bus          : SCCB pads + ROM port (camera_sccb_config_if.master)
//   busy         : pass in progress
//   config_done  : pass complete, sticky until next start or reset
//   writes_done  : SCCB writes completed in the current pass (saturating)
// All outputs are registered.
// ---------------------------------------------------------------------------
module camera_sccb_config #(
    parameter int unsigned CLK_FREQ_HZ  = 24_000_000,
    parameter int unsigned SCCB_FREQ_HZ = 100_000,
    parameter logic [7:0]  DEVICE_ID    = 8'h42,
    parameter int unsigned DELAY_CYCLES = 240_000,
    parameter int unsigned ROM_DEPTH    = 256
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        start,
    camera_sccb_config_if.master        bus,
    output logic                        busy,
    output logic                        config_done,
    output logic [7:0]                  writes_done
);
    localparam int unsigned QDIV       = CLK_FREQ_HZ / (4 * SCCB_FREQ_HZ);
    localparam logic [15:0] QDIV_LAST  = 16'(QDIV - 1);
    localparam logic [31:0] DELAY_LAST = 32'(DELAY_CYCLES - 1);
    localparam logic [7:0]  ADDR_LAST  = 8'(ROM_DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_START,
        S_BITS,
        S_STOP,
        S_GAP,
        S_DELAY,
        S_DONE
    } state_t;

    state_t      state_q,    state_d;
    logic [7:0]  rom_addr_q, rom_addr_d;
    logic        fetch_q,    fetch_d;
    logic [15:0] qcnt_q,     qcnt_d;
    logic [1:0]  quarter_q,  quarter_d;
    logic [3:0]  bit_q,      bit_d;
    logic [1:0]  byte_q,     byte_d;
    logic [23:0] shift_q,    shift_d;
    logic [31:0] delay_q,    delay_d;
    logic [7:0]  writes_q,   writes_d;
    logic        busy_q,     busy_d;
    logic        done_q,     done_d;
    logic        sio_c_q,    sio_c_d;
    logic        sio_d_q,    sio_d_d;
    logic        sio_oe_q,   sio_oe_d;

    logic        tick;
    logic        quarter_end;
    logic        advance;
    logic        ack_slot;

    // Next-state, counters and next output levels.
    always_comb begin
        state_d     = state_q;
        rom_addr_d  = rom_addr_q;
        fetch_d     = fetch_q;
        qcnt_d      = qcnt_q;
        quarter_d   = quarter_q;
        bit_d       = bit_q;
        byte_d      = byte_q;
        shift_d     = shift_q;
        delay_d     = delay_q;
        writes_d    = writes_q;
        busy_d      = busy_q;
        done_d      = done_q;
        advance     = 1'b0;
        ack_slot    = 1'b0;
        tick        = (qcnt_q == QDIV_LAST);
        quarter_end = tick && (quarter_q == 2'd3);

        // The quarter counter only runs while a bus phase is active.
        if (state_q inside {S_START, S_BITS, S_STOP, S_GAP}) begin
            qcnt_d    = tick ? 16'd0 : (qcnt_q + 16'd1);
            quarter_d = tick ? (quarter_q + 2'd1) : quarter_q;
        end else begin
            qcnt_d    = qcnt_q;
            quarter_d = quarter_q;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d    = S_FETCH;
                    rom_addr_d = 8'd0;
                    fetch_d    = 1'b0;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    writes_d   = 8'd0;
                end else begin
                    state_d = state_q;
                end
            end
            S_FETCH: begin
                // First cycle presents the address, second sees ROM data.
                if (!fetch_q) begin
                    fetch_d = 1'b1;
                end else begin
                    fetch_d = 1'b0;
                    if (bus.rom_data == 16'hFFFF) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else if (bus.rom_data == 16'hFFF0) begin
                        state_d = S_DELAY;
                        delay_d = 32'd0;
                    end else begin
                        state_d   = S_START;
                        shift_d   = {DEVICE_ID, bus.rom_data};
                        qcnt_d    = 16'd0;
                        quarter_d = 2'd0;
                        bit_d     = 4'd0;
                        byte_d    = 2'd0;
                    end
                end
            end
            S_START: begin
                state_d = quarter_end ? S_BITS : S_START;
            end
            S_BITS: begin
                // Slot 8 of each byte is the ACK slot: nothing shifts out.
                if (quarter_end) begin
                    if (bit_q == 4'd8) begin
                        bit_d = 4'd0;
                        if (byte_q == 2'd2) begin
                            state_d = S_STOP;
                        end else begin
                            byte_d = byte_q + 2'd1;
                        end
                    end else begin
                        bit_d   = bit_q + 4'd1;
                        shift_d = {shift_q[22:0], 1'b0};
                    end
                end else begin
                    state_d = S_BITS;
                end
            end
            S_STOP: begin
                if (quarter_end) begin
                    state_d  = S_GAP;
                    writes_d = (writes_q == 8'hFF) ? writes_q : (writes_q + 8'd1);
                end else begin
                    state_d = S_STOP;
                end
            end
            S_GAP: begin
                advance = quarter_end;
            end
            S_DELAY: begin
                if (delay_q == DELAY_LAST) begin
                    advance = 1'b1;
                end else begin
                    delay_d = delay_q + 32'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Move to the next ROM entry; the last entry ends the pass (no wrap).
        if (advance) begin
            if (rom_addr_q == ADDR_LAST) begin
                state_d = S_DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end else begin
                state_d    = S_FETCH;
                rom_addr_d = rom_addr_q + 8'd1;
                fetch_d    = 1'b0;
            end
        end else begin
            rom_addr_d = rom_addr_d;
        end

        // Bus levels are derived from the next state so they line up with it.
        sio_c_d  = 1'b1;
        sio_d_d  = 1'b1;
        sio_oe_d = 1'b1;
        case (state_d)
            S_START: begin
                sio_c_d = (quarter_d != 2'd3);
                sio_d_d = (quarter_d == 2'd0);
            end
            S_BITS: begin
                ack_slot = (bit_d == 4'd8);
                sio_c_d  = (quarter_d == 2'd1) || (quarter_d == 2'd2);
                sio_d_d  = ack_slot ? 1'b1 : shift_d[23];
                sio_oe_d = !ack_slot;
            end
            S_STOP: begin
                sio_c_d = (quarter_d != 2'd0);
                sio_d_d = quarter_d[1];
            end
            default: begin
                sio_c_d = 1'b1;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            rom_addr_q <= 8'd0;
            fetch_q    <= 1'b0;
            qcnt_q     <= 16'd0;
            quarter_q  <= 2'd0;
            bit_q      <= 4'd0;
            byte_q     <= 2'd0;
            shift_q    <= 24'd0;
            delay_q    <= 32'd0;
            writes_q   <= 8'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sio_c_q    <= 1'b1;
            sio_d_q    <= 1'b1;
            sio_oe_q   <= 1'b1;
        end else begin
            state_q    <= state_d;
            rom_addr_q <= rom_addr_d;
            fetch_q    <= fetch_d;
            qcnt_q     <= qcnt_d;
            quarter_q  <= quarter_d;
            bit_q      <= bit_d;
            byte_q     <= byte_d;
            shift_q    <= shift_d;
            delay_q    <= delay_d;
            writes_q   <= writes_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            sio_c_q    <= sio_c_d;
            sio_d_q    <= sio_d_d;
            sio_oe_q   <= sio_oe_d;
        end
    end

    assign bus.sio_c    = sio_c_q;
    assign bus.sio_d_o  = sio_d_q;
    assign bus.sio_d_oe = sio_oe_q;
    assign bus.rom_addr = rom_addr_q;
    assign busy         = busy_q;
    assign config_done  = done_q;
    assign writes_done  = writes_q;

endmodule

// File: tb/tb_camera_sccb_config.sv
// ---------------------------------------------------------------------------
// tb_camera_sccb_config
// Two sequencer instances with QDIV=4 and DELAY_CYCLES=50: instance A with
// ROM_DEPTH=256, instance B with ROM_DEPTH=3. A bus monitor per instance
// decodes SCCB bytes at SIO_C rising edges and compares them against bytes
// queued when each pass is launched.
// ---------------------------------------------------------------------------
module tb_camera_sccb_config;
    localparam int QDIV = 4;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b0;
    logic        start_a = 1'b0;
    logic        start_b = 1'b0;
    logic        busy_a, busy_b, done_a, done_b;
    logic [7:0]  wr_a, wr_b;
    int          tests_run    = 0;
    int          tests_failed = 0;
    int          cyc          = 0;
    logic [7:0]  exp_q [$];
    logic [15:0] rom_a [256];
    logic [15:0] rom_b [4];
    logic [7:0]  max_addr_b = 8'd0;
    logic [1:0]  mon_c, mon_d, mon_oe;

    camera_sccb_config_if bus_a ();
    camera_sccb_config_if bus_b ();

    camera_sccb_config #(
        .CLK_FREQ_HZ (400), .SCCB_FREQ_HZ (25), .DEVICE_ID (8'h42),
        .DELAY_CYCLES (50), .ROM_DEPTH (256)
    ) dut_a (
        .clk (clk), .reset_n (reset_n), .start (start_a), .bus (bus_a),
        .busy (busy_a), .config_done (done_a), .writes_done (wr_a)
    );

    camera_sccb_config #(
        .CLK_FREQ_HZ (400), .SCCB_FREQ_HZ (25), .DEVICE_ID (8'h42),
        .DELAY_CYCLES (50), .ROM_DEPTH (3)
    ) dut_b (
        .clk (clk), .reset_n (reset_n), .start (start_b), .bus (bus_b),
        .busy (busy_b), .config_done (done_b), .writes_done (wr_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous ROM models, one cycle read latency.
    always @(posedge clk) bus_a.rom_data <= rom_a[bus_a.rom_addr];
    always @(posedge clk) bus_b.rom_data <= rom_b[bus_b.rom_addr[1:0]];

    always @(negedge clk) begin
        if (busy_b && (bus_b.rom_addr > max_addr_b)) max_addr_b <= bus_b.rom_addr;
    end

    assign mon_c  = {bus_b.sio_c,    bus_a.sio_c};
    assign mon_d  = {bus_b.sio_d_o,  bus_a.sio_d_o};
    assign mon_oe = {bus_b.sio_d_oe, bus_a.sio_d_oe};

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // SCCB bus monitors: START/STOP detection and byte decoding.
    for (genvar g = 0; g < 2; g++) begin : g_mon
        logic       prev_c   = 1'b1;
        logic       prev_d   = 1'b1;
        logic       in_write = 1'b0;
        int         slot     = 0;
        int         starts   = 0;
        int         stops    = 0;
        int         t_fall   = 0;
        logic [7:0] sh       = 8'd0;
        wire  [7:0] nb       = {sh[6:0], mon_d[g]};

        always @(negedge clk) begin
            prev_c <= mon_c[g];
            prev_d <= mon_d[g];
            if (!reset_n) begin
                in_write <= 1'b0;
            end else if (prev_c && mon_c[g] && (mon_d[g] != prev_d)) begin
                // Any D edge while C is high is a START (fall) or STOP (rise).
                if (!mon_d[g]) begin
                    starts   <= starts + 1;
                    in_write <= 1'b1;
                    slot     <= 0;
                    t_fall   <= cyc;
                end else begin
                    stops    <= stops + 1;
                    in_write <= 1'b0;
                end
            end else if (!prev_c && mon_c[g] && in_write && (slot < 27)) begin
                slot <= slot + 1;
                if ((slot % 9) == 8) begin
                    check_eq($sformatf("ack_oe_%0d_slot%0d", g, slot), 32'(mon_oe[g]), 32'd0);
                end else begin
                    check_eq("data_oe", 32'(mon_oe[g]), 32'd1);
                    sh <= nb;
                    if ((slot % 9) == 7) begin
                        if (exp_q.size() == 0)
                            check_eq("sb_unexpected_byte", 32'(nb), 32'hFFFF_FFFF);
                        else
                            check_eq("sb_byte", 32'(nb), 32'(exp_q.pop_front()));
                    end
                end
            end
        end
    end

    task automatic pulse_start(input int which);
        @(negedge clk);
        if (which == 0) start_a = 1'b1; else start_b = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        if (which == 0) begin
            check_eq("start_busy_a", 32'(busy_a), 32'd1);
            check_eq("start_done_clr_a", 32'(done_a), 32'd0);
            check_eq("start_wr_clr_a", 32'(wr_a), 32'd0);
            check_eq("start_addr_a", 32'(bus_a.rom_addr), 32'd0);
        end else begin
            check_eq("start_busy_b", 32'(busy_b), 32'd1);
            check_eq("start_addr_b", 32'(bus_b.rom_addr), 32'd0);
        end
    endtask

    task automatic wait_addr_a(input logic [7:0] a, output int t);
        for (int i = 0; i < 5000; i++) begin
            if (bus_a.rom_addr == a) break;
            @(negedge clk);
        end
        check_eq("wait_addr_a", 32'(bus_a.rom_addr), 32'(a));
        t = cyc;
    endtask

    task automatic wait_done(input int which);
        for (int i = 0; i < 20000; i++) begin
            if ((which == 0) ? done_a : done_b) break;
            @(negedge clk);
        end
        if (which == 0) begin
            check_eq("done_rise_a", 32'(done_a), 32'd1);
            check_eq("done_busy_low_a", 32'(busy_a), 32'd0);
        end else begin
            check_eq("done_rise_b", 32'(done_b), 32'd1);
            check_eq("done_busy_low_b", 32'(busy_b), 32'd0);
        end
    endtask

    task automatic push_write(input logic [15:0] entry);
        exp_q.push_back(8'h42);
        exp_q.push_back(entry[15:8]);
        exp_q.push_back(entry[7:0]);
    endtask

    initial begin
        int s0, p0, t1, t2, viol;

        for (int i = 0; i < 256; i++) rom_a[i] = 16'hFFFF;

        // Reset values.
        repeat (3) @(negedge clk);
        check_eq("rst_sio_c", 32'(bus_a.sio_c), 32'd1);
        check_eq("rst_sio_d", 32'(bus_a.sio_d_o), 32'd1);
        check_eq("rst_sio_oe", 32'(bus_a.sio_d_oe), 32'd1);
        check_eq("rst_addr", 32'(bus_a.rom_addr), 32'd0);
        check_eq("rst_busy", 32'(busy_a), 32'd0);
        check_eq("rst_done", 32'(done_a), 32'd0);
        check_eq("rst_writes", 32'(wr_a), 32'd0);
        reset_n = 1'b1;

        // Single write then end sentinel.
        rom_a[0] = 16'h1280;
        rom_a[1] = 16'hFFFF;
        push_write(16'h1280);
        s0 = g_mon[0].starts;
        p0 = g_mon[0].stops;
        pulse_start(0);
        wait_addr_a(8'd1, t1);
        check_eq("write_len", 32'(t1 - g_mon[0].t_fall + QDIV), 32'd480);
        wait_done(0);
        check_eq("s1_writes", 32'(wr_a), 32'd1);
        check_eq("s1_addr", 32'(bus_a.rom_addr), 32'd1);
        check_eq("s1_starts", 32'(g_mon[0].starts - s0), 32'd1);
        check_eq("s1_stops", 32'(g_mon[0].stops - p0), 32'd1);
        check_eq("s1_sb_empty", 32'(exp_q.size()), 32'd0);

        // Rerun after DONE, with a stray start during BITS.
        push_write(16'h1280);
        s0 = g_mon[0].starts;
        pulse_start(0);
        for (int i = 0; i < 2000; i++) begin
            if (g_mon[0].in_write && (g_mon[0].slot >= 3)) break;
            @(negedge clk);
        end
        check_eq("s4_in_bits", 32'(g_mon[0].slot >= 3), 32'd1);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        @(negedge clk);
        check_eq("s4_ignored_busy", 32'(busy_a), 32'd1);
        check_eq("s4_ignored_addr", 32'(bus_a.rom_addr), 32'd0);
        wait_addr_a(8'd1, t1);
        check_eq("s4_write_len", 32'(t1 - g_mon[0].t_fall + QDIV), 32'd480);
        wait_done(0);
        check_eq("s4_writes", 32'(wr_a), 32'd1);
        check_eq("s4_addr", 32'(bus_a.rom_addr), 32'd1);
        check_eq("s4_starts", 32'(g_mon[0].starts - s0), 32'd1);
        check_eq("s4_sb_empty", 32'(exp_q.size()), 32'd0);

        // Delay sentinel between two writes.
        rom_a[0] = 16'h1100;
        rom_a[1] = 16'hFFF0;
        rom_a[2] = 16'h6B4A;
        rom_a[3] = 16'hFFFF;
        push_write(16'h1100);
        push_write(16'h6B4A);
        s0 = g_mon[0].starts;
        pulse_start(0);
        wait_addr_a(8'd1, t1);
        viol = 0;
        for (int i = 0; i < 5000; i++) begin
            if (bus_a.rom_addr != 8'd1) break;
            if (!bus_a.sio_c || !bus_a.sio_d_o) viol++;
            @(negedge clk);
        end
        t2 = cyc;
        check_eq("s2_addr2", 32'(bus_a.rom_addr), 32'd2);
        check_eq("s2_idle_len_50pm3", 32'((t2 - t1 >= 47) && (t2 - t1 <= 53)), 32'd1);
        check_eq("s2_bus_idle", 32'(viol), 32'd0);
        wait_done(0);
        check_eq("s2_writes", 32'(wr_a), 32'd2);
        check_eq("s2_addr", 32'(bus_a.rom_addr), 32'd3);
        check_eq("s2_starts", 32'(g_mon[0].starts - s0), 32'd2);
        check_eq("s2_sb_empty", 32'(exp_q.size()), 32'd0);

        // ROM_DEPTH=3 with no end sentinel.
        rom_b[0] = 16'h0102;
        rom_b[1] = 16'h0304;
        rom_b[2] = 16'h0506;
        rom_b[3] = 16'h0708;
        push_write(16'h0102);
        push_write(16'h0304);
        push_write(16'h0506);
        pulse_start(1);
        wait_done(1);
        check_eq("s3_writes", 32'(wr_b), 32'd3);
        check_eq("s3_addr", 32'(bus_b.rom_addr), 32'd2);
        check_eq("s3_max_addr", 32'(max_addr_b), 32'd2);
        check_eq("s3_starts", 32'(g_mon[1].starts), 32'd3);
        check_eq("s3_stops", 32'(g_mon[1].stops), 32'd3);
        check_eq("s3_sb_empty", 32'(exp_q.size()), 32'd0);

        // Reset pulse in the middle of byte 2.
        rom_a[0] = 16'h1280;
        rom_a[1] = 16'hFFFF;
        exp_q.push_back(8'h42);
        s0 = g_mon[0].starts;
        p0 = g_mon[0].stops;
        pulse_start(0);
        for (int i = 0; i < 2000; i++) begin
            if (g_mon[0].in_write && (g_mon[0].slot >= 12)) break;
            @(negedge clk);
        end
        check_eq("s5_in_byte2", 32'(g_mon[0].slot >= 12), 32'd1);
        reset_n = 1'b0;
        @(negedge clk);
        check_eq("s5_sio_c", 32'(bus_a.sio_c), 32'd1);
        check_eq("s5_sio_d", 32'(bus_a.sio_d_o), 32'd1);
        check_eq("s5_sio_oe", 32'(bus_a.sio_d_oe), 32'd1);
        check_eq("s5_busy", 32'(busy_a), 32'd0);
        check_eq("s5_done", 32'(done_a), 32'd0);
        #1 reset_n = 1'b1;
        viol = 0;
        repeat (300) begin
            @(negedge clk);
            if (!bus_a.sio_c || !bus_a.sio_d_o || !bus_a.sio_d_oe || busy_a) viol++;
        end
        check_eq("s5_quiet", 32'(viol), 32'd0);
        check_eq("s5_starts", 32'(g_mon[0].starts - s0), 32'd1);
        check_eq("s5_stops", 32'(g_mon[0].stops - p0), 32'd0);
        check_eq("s5_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/camera_sccb_config.md
# camera_sccb_config

Boot-time register configuration sequencer for the OV7670 camera. It walks a register ROM of {reg_addr, value} pairs and issues one 3-phase SCCB write per entry: device ID, register address, data. The ROM supports delay and end sentinels. It runs on the 24 MHz camera clock domain beside the clock wizard, VGA and HDMI blocks, and its `config_done` gates the capture path.

## Interface
Parameters:
- `CLK_FREQ_HZ`, 24_000_000, frequency of `clk`.
- `SCCB_FREQ_HZ`, 100_000, SIO_C bit rate. `QDIV = CLK_FREQ_HZ/(4*SCCB_FREQ_HZ)` is the number of clk cycles per quarter-bit; it must be ≥ 1 (60 at defaults).
- `DEVICE_ID`, 8'h42, SCCB write ID.
- `DELAY_CYCLES`, 240_000, length of the delay-sentinel wait (10 ms at defaults).
- `ROM_DEPTH`, 256, number of ROM entries (≤ 256).

Ports:
- `clk` in 1: camera-domain clock.
- `reset_n` in 1: synchronous, active-low reset.
- `start` in 1: single-cycle pulse that begins a configuration pass.
- `rom_addr` out 8: ROM entry index.
- `rom_data` in 16: {reg_addr[15:8], value[7:0]}. Synchronous ROM with 1-cycle read latency.
- `sio_c` out 1: SCCB clock, push-pull.
- `sio_d_o` out 1: SCCB data value.
- `sio_d_oe` out 1: SCCB data drive enable. The top level tristates the pad when this is 0.
- `busy` out 1: high while a pass is in progress.
- `config_done` out 1: high after a pass completes; sticky until the next `start` or reset.
- `writes_done` out 8: count of SCCB writes completed in the current pass.

## Operation
- Reset values: `sio_c`=1, `sio_d_o`=1, `sio_d_oe`=1, `rom_addr`=0, `busy`=0, `config_done`=0, `writes_done`=0. All internal counters are cleared. The FSM is in IDLE.
- States: IDLE, FETCH, START, BITS, STOP, GAP, DELAY, DONE.
- IDLE → FETCH on `start`.
  - `rom_addr` is set to 0.
  - `busy`=1, `config_done`=0, `writes_done`=0.
  - `start` is ignored in every state except IDLE and DONE.
- DONE: `busy`=0 and `config_done`=1. On `start`, behaves exactly like IDLE (the pass restarts at entry 0).
- FETCH: holds for 2 cycles (address presented, then data valid), then samples `rom_data` and decodes it:
  - 16'hFFFF → DONE.
  - 16'hFFF0 → DELAY.
  - Anything else → START, with shift content {DEVICE_ID, reg_addr, value}.
- DELAY: counts `DELAY_CYCLES` clk cycles, then advances to the next entry.
- Advancing to the next entry (from GAP or DELAY):
  - If `rom_addr` == ROM_DEPTH-1 → DONE. There is no wrap.
  - Otherwise `rom_addr` increments and the FSM goes to FETCH.
- Quarter tick: a counter produces one tick every QDIV cycles while in START, BITS, STOP or GAP. Each phase below spans 4 quarters (q0..q3); the levels listed hold during that quarter.
- START:
  - q0: C=1, D=1.
  - q1: C=1, D=0.
  - q2: C=1, D=0.
  - q3: C=0, D=0.
- BITS: 27 bit slots, 3 bytes × (8 data bits MSB-first + 1 don't-care bit).
  - q0: C=0, D=bit.
  - q1: C=1.
  - q2: C=1.
  - q3: C=0.
  - Don't-care slots: `sio_d_oe`=0 for all 4 quarters. The ACK/NACK value is not sampled and does not affect sequencing.
- STOP:
  - q0: C=0, D=0.
  - q1: C=1, D=0.
  - q2: C=1, D=1.
  - q3: C=1, D=1.
  - On completion, `writes_done` increments (saturating at 255).
- GAP: 4 quarters with C=1, D=1 (bus idle), then advance to the next entry.
- Outside the bus phases (IDLE, FETCH, DELAY, DONE), all SCCB outputs are at their reset values.
- Reset mid-transaction: on the next clk edge all outputs return to reset values. No STOP is generated. The camera recovers on the next START. There is no automatic retry; a new `start` is required.

## Timing
- All outputs are registered, with no combinational path from inputs to outputs.
- `start` → `busy`=1 and `rom_addr`=0 on the following edge.
- One write transaction (START + BITS + STOP + GAP) = 4 + 108 + 4 + 4 = 120 quarters = 120·QDIV cycles (7200 cycles / 300 µs at defaults).
- Per-entry overhead: 2 FETCH cycles plus 1 decode/transition cycle.
- SIO_D changes only while SIO_C is low, except the START and STOP edges.
- Data is stable for ≥ 2 quarters around the SIO_C rising edge.
- `config_done` rises in the same cycle that `busy` falls.

## Test plan
- QDIV=4, ROM {16'h1280, 16'hFFFF}, pulse `start`:
  - Sampling `sio_d_o` at `sio_c` rising edges gives 0x42, x, 0x12, x, 0x80, x.
  - `sio_d_oe`=0 in slots 9, 18 and 27.
  - Exactly 480 cycles from START q0 to GAP end.
  - Then `config_done`=1, `busy`=0, `writes_done`=1, `rom_addr`=1.
- ROM {16'h1100, 16'hFFF0, 16'h6B4A, 16'hFFFF}, DELAY_CYCLES=50:
  - Two writes are observed.
  - The bus stays idle (C=D=1) for 50 cycles (±3 for fetch) between them.
  - `writes_done`=2.
- ROM_DEPTH=3 with no end sentinel, entries 16'h0102, 16'h0304, 16'h0506:
  - Three writes, then DONE with `rom_addr`=2.
  - There is no fetch of address 3.
- `start` pulsed during the BITS of the first write:
  - Ignored; the output sequence is identical to the first scenario.
  - A second `start` after DONE reruns the pass, with `config_done` dropping on the next edge and `writes_done` restarting from 0.
- `reset_n`=0 for 1 cycle in the middle of byte 2:
  - On the next edge, `sio_c`=1, `sio_d_o`=1, `sio_d_oe`=1, `busy`=0, `config_done`=0.
  - No further bus activity occurs until `start`.
- Check the START and STOP conditions:
  - START: D falls while C=1.
  - STOP: D rises while C=1.
  - No other D transition occurs while C=1 during any pass.
